// File: rtl/charattr_pkg.sv
// Shared types and defaults for the character/attribute ping-pong row store.
package charattr_pkg;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } wr_state_e;

    localparam int DEFAULT_COLUMNS    = 100;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // The column counter must be wide enough to address every column of a row.
    function automatic bit col_width_ok(input int columns, input int col_width);
        return $clog2(columns) <= col_width;
    endfunction

endpackage

// File: rtl/charattr_sdp_ram.sv
// Generic simple dual-port RAM: one write port, one registered read port, one clock.
module charattr_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // No reset on the array or the read register so synthesis can map to block RAM.
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/charattr_row_pingpong.sv
// Double-buffered character/attribute row store: the producer fills the back bank
// while the renderer reads the front bank; banks exchange only on a complete row.
module charattr_row_pingpong
    import charattr_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int COLUMNS    = DEFAULT_COLUMNS,
    parameter int COL_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [COL_WIDTH-1:0]  wr_col,
    input  logic [COL_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_next_row,
    output logic                  front_valid,
    output logic                  underrun
);

    if (COLUMNS < 2 || !col_width_ok(COLUMNS, COL_WIDTH)) begin : g_bad_params
        $error("charattr_row_pingpong: COLUMNS must be >= 2 and fit in COL_WIDTH bits");
    end

    localparam logic [COL_WIDTH-1:0] LAST_COL  = COL_WIDTH'(COLUMNS - 1);
    localparam logic [COL_WIDTH:0]   COL_LIMIT = (COL_WIDTH + 1)'(COLUMNS);

    wr_state_e              state_q, state_d;
    logic [COL_WIDTH-1:0]   wr_col_q, wr_col_d;
    logic                   front_q, front_d;
    logic                   front_valid_q, front_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   rd_ok_q, rd_ok_d;
    logic                   wr_accept;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    // Handshake: a word transfers on any clock edge where wr_valid and wr_ready are both high.
    assign wr_accept = wr_valid && (state_q == FILLING);

    always_comb begin
        state_d       = state_q;
        wr_col_d      = wr_col_q;
        front_d       = front_q;
        front_valid_d = front_valid_q;
        underrun_d    = 1'b0;
        // Masking decision is taken with the address, so it lines up with the RAM output.
        rd_ok_d       = front_valid_q && ({1'b0, rd_addr} < COL_LIMIT);
        case (state_q)
            FILLING: begin
                if (wr_accept) begin
                    if (wr_col_q == LAST_COL) begin
                        wr_col_d = '0;
                        state_d  = FULL;
                    end else begin
                        wr_col_d = wr_col_q + COL_WIDTH'(1);
                    end
                end
                // A row completing in this same cycle is not yet FULL: still an underrun.
                if (rd_next_row) begin
                    underrun_d = 1'b1;
                end
            end
            FULL: begin
                if (rd_next_row) begin
                    front_d       = ~front_q;
                    front_valid_d = 1'b1;
                    state_d       = FILLING;
                end
            end
            default: state_d = FILLING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FILLING;
            wr_col_q      <= '0;
            front_q       <= 1'b0;
            front_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_col_q      <= wr_col_d;
            front_q       <= front_d;
            front_valid_q <= front_valid_d;
            underrun_q    <= underrun_d;
            rd_ok_q       <= rd_ok_d;
        end
    end

    // Physical address is {bank, column}; the array spans the full column address range.
    charattr_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (COL_WIDTH + 1)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_accept),
        .waddr_i ({~front_q, wr_col_q}),
        .wdata_i (wr_data),
        .raddr_i ({front_q, rd_addr}),
        .rdata_o (ram_rdata)
    );

    assign wr_ready    = (state_q == FILLING);
    assign wr_col      = wr_col_q;
    assign front_valid = front_valid_q;
    assign underrun    = underrun_q;
    assign rd_data     = rd_ok_q ? ram_rdata : '0;

endmodule

// File: doc/charattr_row_pingpong.md
Name: charattr_row_pingpong

Overview:
- Parametrised, double-buffered row store for character/attribute words.
- A producer fills one bank (the back bank) column by column while the video pipeline reads the other (the front bank) by random column address.
- At each row boundary the reader requests a swap; the banks exchange only when the back bank is complete. Otherwise the previous row is repeated and an underrun is flagged.
- Sits between the text-memory fetch unit and the glyph renderer, in the single video clock domain.

Parameters:
- DATA_WIDTH, 32, bits per character/attribute word.
- COLUMNS, 100, words per row; must be at least 2.
- COL_WIDTH, 7, column address width; requires 2**COL_WIDTH >= COLUMNS.

Ports:
- clk  input  1  video clock.
- reset  input  1  synchronous, active-low reset.
- wr_valid  input  1  producer offers wr_data.
- wr_data  input  DATA_WIDTH  word for the next column of the back bank.
- wr_ready  output  1  back bank accepts a word this cycle.
- wr_col  output  COL_WIDTH  column the next accepted word will occupy.
- rd_addr  input  COL_WIDTH  column to read from the front bank.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_next_row  input  1  one-cycle row-boundary pulse, asking for a swap.
- front_valid  output  1  front bank holds a committed row.
- underrun  output  1  one-cycle pulse: swap requested but back bank incomplete.

Behaviour:
- Reset (reset=0 at a clk edge):
  - wr_col=0, wr_ready=1, front_valid=0, underrun=0, rd_data=0.
  - Bank select front=0, back=1; writer state FILLING.
  - RAM contents are not cleared.
- Memory and addressing:
  - 2*COLUMNS words; physical address = {bank, column}.
  - One write port and one read port, same clock.
- Writer FSM, states FILLING and FULL:
  - FILLING: wr_ready=1. Accept when wr_valid & wr_ready; the word is written at {back, wr_col}.
  - After each accept, wr_col increments. An accept at wr_col=COLUMNS-1 wraps wr_col to 0 and moves to FULL.
  - FULL: wr_ready=0 and writes are ignored; wr_col stays 0.
- Swap (rd_next_row=1):
  - FULL in the same cycle: next cycle the banks exchange, the writer returns to FILLING and front_valid becomes 1.
  - FILLING: no exchange. underrun=1 for exactly the next cycle. front bank, front_valid and the writer's progress are unchanged.
  - The last accepted word and rd_next_row in the same cycle: FULL is not yet registered, so the result is an underrun. The row completes and is swapped at the next rd_next_row.
  - A swap in FULL takes precedence over everything; no write can be accepted in FULL.
- Read:
  - Latency 1. rd_data at edge n+1 reflects rd_addr and the front bank at edge n.
  - A read issued in the same cycle as rd_next_row returns old-front data.
  - rd_data=0 when front_valid=0, or when rd_addr >= COLUMNS.
- Reset mid-row discards the partial row and any pending FULL; it is safe in any state.

Decomposition:
- Shared package (charattr_pkg):
  - writer state enum {FILLING, FULL};
  - default COLUMNS and DATA_WIDTH constants;
  - the rule function clog2(COLUMNS) <= COL_WIDTH.
- Sub-module charattr_sdp_ram:
  - generic inferred simple dual-port RAM, depth 2*COLUMNS, width DATA_WIDTH;
  - registered read, no reset on the array;
  - parametrised so the vendor BRAM mapping is left to synthesis.
- The top level holds the FSM, counters, bank select and output masking.

Test Plan (COLUMNS=4, DATA_WIDTH=32 unless stated):
- Fill after reset: write 0xA0..0xA3 with wr_valid held 1 -> wr_ready drops after the 4th accept. Pulse rd_next_row -> front_valid=1. Read addresses 0..3 -> 0xA0..0xA3, one cycle later each.
- Underrun: after the swap above, write only 0xB0,0xB1 and pulse rd_next_row -> underrun=1 for one cycle. Reads still return 0xA0..0xA3 and wr_col=2. Write 0xB2,0xB3 and pulse again -> reads return 0xB0..0xB3.
- Same-cycle completion: the last write and rd_next_row in one cycle -> underrun pulse, no swap. The next rd_next_row swaps.
- Backpressure: in FULL, drive wr_valid=1 with 0xDEAD for 5 cycles -> no accept and wr_col=0. After the swap, the first accepted word lands at column 0.
- Out-of-range and invalid reads: rd_addr=5 -> rd_data=0. Immediately after reset, read address 0 -> rd_data=0 regardless of RAM contents.
- Reset mid-fill: after 2 writes, assert reset=0 for one cycle -> wr_col=0 and front_valid=0. A full refill of 4 words plus a swap reads back the new data only.
